// File: rtl/cmd_fetch_buffer_if.sv
// ---------------------------------------------------------------------------
// cmd_fetch_buffer_if
// Bundles the command-supply handshake and status signals between the
// upstream word source / control FSM (master) and cmd_fetch_buffer (slave).
//
// Signals:
//   s_valid    master->slave  upstream word valid
//   s_ready    slave->master  buffer can accept a word (not full)
//   s_data     master->slave  {parity, command[CMD_W-1:0]}
//   take       master->slave  consume strobe (control datain_reg_en)
//   flush      master->slave  synchronous FIFO clear
//   err_clr    master->slave  synchronous clear of err_count
//   cmd_out    slave->master  current command (registered)
//   p_error    slave->master  parity error flag travelling with cmd_out
//   cmd_valid  slave->master  1 = cmd_out from FIFO, 0 = injected NOP
//   level      slave->master  FIFO occupancy 0..DEPTH
//   err_count  slave->master  saturating count of bad-parity words accepted
// ---------------------------------------------------------------------------
interface cmd_fetch_buffer_if #(
    parameter int CMD_W = 7,
    parameter int DEPTH = 4
) ();
    logic                     s_valid;
    logic                     s_ready;
    logic [CMD_W:0]           s_data;
    logic                     take;
    logic                     flush;
    logic                     err_clr;
    logic [CMD_W-1:0]         cmd_out;
    logic                     p_error;
    logic                     cmd_valid;
    logic [$clog2(DEPTH):0]   level;
    logic [7:0]               err_count;

    modport master (
        output s_valid, s_data, take, flush, err_clr,
        input  s_ready, cmd_out, p_error, cmd_valid, level, err_count
    );

    modport slave (
        input  s_valid, s_data, take, flush, err_clr,
        output s_ready, cmd_out, p_error, cmd_valid, level, err_count
    );
endinterface

// File: rtl/cmd_fetch_buffer.sv
// ---------------------------------------------------------------------------
// cmd_fetch_buffer
// Command-supply stage for the CPU control FSM. Parity-protected words are
// accepted over a valid/ready handshake, tagged with a parity-error bit and
// buffered in a DEPTH-entry FIFO. One command at a time is presented on the
// registered cmd_out/p_error pair; a take strobe loads the next FIFO head, or
// a NOP (low three bits 3'b111) when the FIFO is empty, so the FSM idles.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   asynchronous active-high reset
//   bus   cmd_fetch_buffer_if.slave (handshake, control strobes, status)
// ---------------------------------------------------------------------------
module cmd_fetch_buffer #(
    parameter int CMD_W      = 7,
    parameter int DEPTH      = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               rst,
    cmd_fetch_buffer_if.slave  bus
);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = AW + 1;
    localparam int ENT_W = CMD_W + 1;

    localparam logic [CMD_W-1:0] NOP_CMD    = CMD_W'(3'b111);
    localparam logic [LW-1:0]    LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]    LEVEL_ONE  = LW'(1'b1);
    localparam logic [LW-1:0]    LEVEL_ZERO = {LW{1'b0}};
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1'b1);
    localparam logic [AW-1:0]    PTR_ZERO   = {AW{1'b0}};
    localparam logic [7:0]       ERR_MAX    = 8'hFF;

    // Error bit of an incoming word: 1 when its overall parity is wrong.
    function automatic logic parity_err(input logic [CMD_W:0] word);
        logic err;
        if (PARITY_ODD != 0) begin
            err = ~^word;
        end else begin
            err = ^word;
        end
        return err;
    endfunction

    // FIFO storage: each entry is {error bit, command}
    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic [CMD_W-1:0] cmd_q,    cmd_d;
    logic             perr_q,   perr_d;
    logic             cv_q,     cv_d;
    logic [7:0]       errc_q,   errc_d;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             in_err_s;
    logic [ENT_W-1:0] head_s;

    // Handshake qualification; flush suppresses both push and pop.
    always_comb begin
        full_s   = (level_q == LEVEL_FULL);
        empty_s  = (level_q == LEVEL_ZERO);
        push_s   = bus.s_valid && !full_s && !bus.flush;
        pop_s    = bus.take && !empty_s && !bus.flush;
        in_err_s = parity_err(bus.s_data);
        head_s   = mem_q[rd_ptr_q];
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (bus.flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            level_d  = LEVEL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LEVEL_ONE;
                2'b01:   level_d = level_q - LEVEL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Output register next-state: take loads the head, or a NOP when nothing
    // is poppable (empty, or flushed this cycle). A word pushed on the same
    // edge is never bypassed to the output.
    always_comb begin
        cmd_d  = cmd_q;
        perr_d = perr_q;
        cv_d   = cv_q;
        if (bus.take) begin
            if (pop_s) begin
                cmd_d  = head_s[CMD_W-1:0];
                perr_d = head_s[CMD_W];
                cv_d   = 1'b1;
            end else begin
                cmd_d  = NOP_CMD;
                perr_d = 1'b0;
                cv_d   = 1'b0;
            end
        end else begin
            cmd_d  = cmd_q;
            perr_d = perr_q;
            cv_d   = cv_q;
        end
    end

    // Saturating bad-parity counter; clear wins over a same-cycle increment.
    always_comb begin
        errc_d = errc_q;
        if (bus.err_clr) begin
            errc_d = 8'h00;
        end else if (push_s && in_err_s && (errc_q != ERR_MAX)) begin
            errc_d = errc_q + 8'h01;
        end else begin
            errc_d = errc_q;
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            level_q  <= LEVEL_ZERO;
            cmd_q    <= NOP_CMD;
            perr_q   <= 1'b0;
            cv_q     <= 1'b0;
            errc_q   <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cmd_q    <= cmd_d;
            perr_q   <= perr_d;
            cv_q     <= cv_d;
            errc_q   <= errc_d;
        end
    end

    // FIFO storage write; entries are cleared on reset so no stale data leaks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENT_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {in_err_s, bus.s_data[CMD_W-1:0]};
        end
    end

    assign bus.s_ready   = !full_s;
    assign bus.cmd_out   = cmd_q;
    assign bus.p_error   = perr_q;
    assign bus.cmd_valid = cv_q;
    assign bus.level     = level_q;
    assign bus.err_count = errc_q;
endmodule

// File: doc/cmd_fetch_buffer.md
Name: cmd_fetch_buffer

Overview:
Upstream command-supply stage for the CPU control FSM. Accepts parity-protected command words over a valid/ready handshake and checks their parity. Buffers them in a small FIFO and presents one command at a time on a registered cmd_out/p_error pair. The control FSM's datain_reg_en pulse (wired to take) advances to the next command. When no command is available, a NOP (low 3 bits = 3'b111) is presented so the FSM idles harmlessly.

Parameters:
CMD_W, 7, command width; must be >= 3.
DEPTH, 4, FIFO entries; power of two, >= 2.
PARITY_ODD, 0, 0 = even parity over all CMD_W+1 bits, 1 = odd parity.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset (see Behaviour)
s_valid  in  1  upstream word valid
s_ready  out  1  buffer can accept; = !full (combinational from occupancy)
s_data  in  CMD_W+1  bit CMD_W = parity, bits CMD_W-1:0 = command
take  in  1  consume strobe from control datain_reg_en
flush  in  1  synchronous FIFO clear
err_clr  in  1  synchronous clear of err_count
cmd_out  out  CMD_W  current command to control cmd_in (registered)
p_error  out  1  parity error flag of cmd_out (registered)
cmd_valid  out  1  1 = cmd_out came from FIFO, 0 = injected NOP
level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
err_count  out  8  count of accepted words with bad parity

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - cmd_out = NOP (bits 2:0 = 3'b111, all other bits 0); p_error = 0; cmd_valid = 0.
  - level = 0; read/write pointers = 0; err_count = 0.
  - s_ready = 1 immediately after reset.
- Reset mid-operation discards all buffered words and the current command.
- Push:
  - A word is accepted when s_valid && s_ready on a clock edge.
  - The entry stores command bits plus an error bit:
    - PARITY_ODD=0: error bit = ^s_data.
    - PARITY_ODD=1: error bit = ~^s_data.
  - Upstream must hold s_data stable while s_valid && !s_ready.
- Full: s_ready = 0 when level == DEPTH, even if take is asserted in the same cycle. There is no push-through-on-pop and no overflow is possible.
- Pop (take=1):
  - If level > 0 at the edge: cmd_out/p_error <= head entry, cmd_valid <= 1, read pointer advances.
  - If level == 0: cmd_out <= NOP, p_error <= 0, cmd_valid <= 0.
  - take=0: cmd_out, p_error and cmd_valid hold their values.
- Latency: a word pushed at edge N is eligible for take at edge N+1 or later. A same-cycle push into an empty FIFO with take is not bypassed: the NOP is loaded and the word stays buffered.
- Simultaneous push and pop when 0 < level < DEPTH: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. level distinguishes full from empty.
- flush=1:
  - Pointers and level are cleared; any same-cycle push is dropped.
  - A same-cycle take loads NOP (flush has priority over pop).
  - cmd_out is not cleared unless take is also asserted.
- err_count:
  - +1 on each accepted word whose error bit = 1; saturates at 255.
  - err_clr=1 forces 0 and has priority over a same-cycle increment.
  - A word dropped by flush is not counted.
- A p_error flag travels with its command. The control FSM only uses it in EXECUTE for register-select 2'b11.
- No other state machine is needed: FIFO control plus the output register. Occupancy is tracked by counter.

Test Plan:
1. Reset → cmd_out=7'b0000111, p_error=0, cmd_valid=0, level=0, s_ready=1, err_count=0.
2. Push s_data=8'b0_0100001 (even parity OK) then take → cmd_out=7'b0100001, p_error=0, cmd_valid=1, level back to 0.
3. Push s_data=8'b1_0100001 (bad even parity) then take → cmd_out=7'b0100001, p_error=1, err_count=1. Same word with PARITY_ODD=1 → p_error=0.
4. Push 4 words 7'h01..7'h04 with no take → level=4, s_ready=0. A 5th word with s_valid held stays unaccepted. Four takes → cmd_out=7'h01, 7'h02, 7'h03, 7'h04 in order. A fifth take → NOP, cmd_valid=0.
5. At level=2, push and take in the same cycle for 6 cycles (pointer wrap) → level stays 2, commands emerge in push order with none lost or duplicated.
6. Push 256 bad-parity words with interleaved takes → err_count saturates at 255. err_clr asserted together with a bad-parity push → err_count=0. flush at level=3 → level=0, cmd_out unchanged.
